// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter in front of a single-outstanding memory port.
//
// An instruction-fetch requester (i_*) and a data requester (d_*) share one memory
// port (m_*). At most one transaction is in flight. When both ask in the same idle
// cycle the data side wins, unless it has already won STARVE_MAX times in a row while
// fetch was waiting; then fetch wins once and the count starts over.
//
// Ports
//   clk, rst                    rising-edge clock, asynchronous active-high reset
//   i_req_i, i_addr_i           fetch read request and address
//   i_gnt_o                     fetch grant pulse (idle cycle only)
//   i_rvalid_o, i_rdata_o       fetch read data, forwarded from the memory port
//   d_req_i, d_we_i, d_addr_i,  data request, write enable, address,
//   d_wdata_i, d_wstrb_i        write data and byte strobes
//   d_gnt_o                     data grant pulse (idle cycle only)
//   d_rvalid_o, d_rdata_o       load data, forwarded from the memory port
//   m_req_o, m_we_o, m_addr_o,  memory request and payload; the payload holds
//   m_wdata_o, m_wstrb_o        its last latched value when no request is active
//   m_ready_i                   memory accepts the request
//   m_rvalid_i, m_rdata_i       memory read response
//   busy_o                      high whenever the arbiter is not idle
//   err_o                       sticky: a read response arrived with none pending

module mem_arbiter #(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned AW         = 32
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          i_req_i,
    input  logic [AW-1:0] i_addr_i,
    output logic          i_gnt_o,
    output logic          i_rvalid_o,
    output logic [31:0]   i_rdata_o,

    input  logic          d_req_i,
    input  logic          d_we_i,
    input  logic [AW-1:0] d_addr_i,
    input  logic [31:0]   d_wdata_i,
    input  logic [3:0]    d_wstrb_i,
    output logic          d_gnt_o,
    output logic          d_rvalid_o,
    output logic [31:0]   d_rdata_o,

    output logic          m_req_o,
    output logic          m_we_o,
    output logic [AW-1:0] m_addr_o,
    output logic [31:0]   m_wdata_o,
    output logic [3:0]    m_wstrb_o,
    input  logic          m_ready_i,
    input  logic          m_rvalid_i,
    input  logic [31:0]   m_rdata_i,

    output logic          busy_o,
    output logic          err_o
);

    // Counter is at least 3 bits wide and wide enough to hold STARVE_MAX.
    localparam int unsigned SW = ($clog2(STARVE_MAX + 1) > 3) ? $clog2(STARVE_MAX + 1) : 3;
    localparam logic [SW-1:0] StarveMax = SW'(STARVE_MAX);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait
    } state_e;

    typedef enum logic {
        OwnI,
        OwnD
    } owner_e;

    state_e          state_q;
    owner_e          owner_q;
    logic [SW-1:0]   starve_q;
    logic            m_we_q;
    logic [AW-1:0]   m_addr_q;
    logic [31:0]     m_wdata_q;
    logic [3:0]      m_wstrb_q;
    logic            err_q;

    logic in_idle;
    logic starved;
    logic pick_d;
    logic pick_i;

    // Arbitration decision, valid only while idle.
    always_comb begin
        in_idle = (state_q == StIdle);
        starved = (starve_q == StarveMax);
        pick_d  = d_req_i && !(i_req_i && starved);
        pick_i  = i_req_i && !pick_d;
    end

    // Single FSM/datapath register block. The grant decision uses the ungated
    // pick_* terms; rst only gates the combinational grant outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            owner_q   <= OwnI;
            starve_q  <= '0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_wstrb_q <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (pick_i) begin
                        owner_q   <= OwnI;
                        m_we_q    <= 1'b0;
                        m_addr_q  <= i_addr_i;
                        m_wdata_q <= '0;
                        m_wstrb_q <= '0;
                        state_q   <= StIssue;
                    end else if (pick_d) begin
                        owner_q   <= OwnD;
                        m_we_q    <= d_we_i;
                        m_addr_q  <= d_addr_i;
                        m_wdata_q <= d_wdata_i;
                        m_wstrb_q <= d_wstrb_i;
                        state_q   <= StIssue;
                    end

                    // Count only data wins that actually made fetch wait.
                    if (pick_i || !i_req_i) begin
                        starve_q <= '0;
                    end else if (pick_d && (starve_q != StarveMax)) begin
                        starve_q <= starve_q + SW'(1);
                    end
                end
                StIssue: begin
                    if (m_ready_i) begin
                        // Writes finish at acceptance; reads wait for the response.
                        state_q <= m_we_q ? StIdle : StWait;
                    end
                end
                StWait: begin
                    if (m_rvalid_i) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase

            // A response with no read outstanding is a protocol error; it is dropped.
            if (m_rvalid_i && (state_q != StWait)) begin
                err_q <= 1'b1;
            end
        end
    end

    logic fwd;

    always_comb begin
        i_gnt_o    = in_idle && !rst && pick_i;
        d_gnt_o    = in_idle && !rst && pick_d;

        // Read data is forwarded in the same cycle the memory returns it.
        fwd        = (state_q == StWait) && m_rvalid_i;
        i_rvalid_o = fwd && (owner_q == OwnI);
        d_rvalid_o = fwd && (owner_q == OwnD);
        i_rdata_o  = i_rvalid_o ? m_rdata_i : '0;
        d_rdata_o  = d_rvalid_o ? m_rdata_i : '0;

        m_req_o    = (state_q == StIssue);
        m_we_o     = m_we_q;
        m_addr_o   = m_addr_q;
        m_wdata_o  = m_wdata_q;
        m_wstrb_o  = m_wstrb_q;

        busy_o     = !in_idle;
        err_o      = err_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed, table-driven bench for mem_arbiter (STARVE_MAX=4, AW=32).
// Each table row is one clock cycle: inputs are driven after the falling edge and the
// outputs are compared 1 ns later, well before the next rising edge.

module tb_mem_arbiter;

    localparam int unsigned AW = 32;

    logic          clk;
    logic          rst;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt;
    logic          i_rvalid;
    logic [31:0]   i_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata;
    logic [3:0]    d_wstrb;
    logic          d_gnt;
    logic          d_rvalid;
    logic [31:0]   d_rdata;
    logic          m_req;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_wdata;
    logic [3:0]    m_wstrb;
    logic          m_ready;
    logic          m_rvalid;
    logic [31:0]   m_rdata;
    logic          busy;
    logic          err;

    int n_checks;
    int n_fail;

    mem_arbiter #(
        .STARVE_MAX (4),
        .AW         (AW)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .i_req_i    (i_req),
        .i_addr_i   (i_addr),
        .i_gnt_o    (i_gnt),
        .i_rvalid_o (i_rvalid),
        .i_rdata_o  (i_rdata),
        .d_req_i    (d_req),
        .d_we_i     (d_we),
        .d_addr_i   (d_addr),
        .d_wdata_i  (d_wdata),
        .d_wstrb_i  (d_wstrb),
        .d_gnt_o    (d_gnt),
        .d_rvalid_o (d_rvalid),
        .d_rdata_o  (d_rdata),
        .m_req_o    (m_req),
        .m_we_o     (m_we),
        .m_addr_o   (m_addr),
        .m_wdata_o  (m_wdata),
        .m_wstrb_o  (m_wstrb),
        .m_ready_i  (m_ready),
        .m_rvalid_i (m_rvalid),
        .m_rdata_i  (m_rdata),
        .busy_o     (busy),
        .err_o      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        // inputs
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic [3:0]  dwstrb;
        logic        mready;
        logic        mrvalid;
        logic [31:0] mrdata;
        // expected outputs
        logic        ig;
        logic        dg;
        logic        irv;
        logic [31:0] ird;
        logic        drv;
        logic [31:0] drd;
        logic        mreq;
        logic        mwe;
        logic [31:0] maddr;
        logic [31:0] mwdata;
        logic [3:0]  mwstrb;
        logic        bsy;
        logic        er;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input int unsigned ireq, input int unsigned iaddr, input int unsigned dreq,
        input int unsigned dwe, input int unsigned daddr, input int unsigned dwdata,
        input int unsigned dwstrb, input int unsigned mready, input int unsigned mrvalid,
        input int unsigned mrdata, input int unsigned ig, input int unsigned dg,
        input int unsigned irv, input int unsigned ird, input int unsigned drv,
        input int unsigned drd, input int unsigned mreq, input int unsigned mwe,
        input int unsigned maddr, input int unsigned mwdata, input int unsigned mwstrb,
        input int unsigned bsy, input int unsigned er);
        vec_t v;
        v.ireq    = 1'(ireq);
        v.iaddr   = iaddr;
        v.dreq    = 1'(dreq);
        v.dwe     = 1'(dwe);
        v.daddr   = daddr;
        v.dwdata  = dwdata;
        v.dwstrb  = 4'(dwstrb);
        v.mready  = 1'(mready);
        v.mrvalid = 1'(mrvalid);
        v.mrdata  = mrdata;
        v.ig      = 1'(ig);
        v.dg      = 1'(dg);
        v.irv     = 1'(irv);
        v.ird     = ird;
        v.drv     = 1'(drv);
        v.drd     = drd;
        v.mreq    = 1'(mreq);
        v.mwe     = 1'(mwe);
        v.maddr   = maddr;
        v.mwdata  = mwdata;
        v.mwstrb  = 4'(mwstrb);
        v.bsy     = 1'(bsy);
        v.er      = 1'(er);
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive_idle();
        i_req    = 1'b0;
        i_addr   = '0;
        d_req    = 1'b0;
        d_we     = 1'b0;
        d_addr   = '0;
        d_wdata  = '0;
        d_wstrb  = '0;
        m_ready  = 1'b0;
        m_rvalid = 1'b0;
        m_rdata  = '0;
    endtask

    task automatic apply(input vec_t v);
        i_req    = v.ireq;
        i_addr   = v.iaddr;
        d_req    = v.dreq;
        d_we     = v.dwe;
        d_addr   = v.daddr;
        d_wdata  = v.dwdata;
        d_wstrb  = v.dwstrb;
        m_ready  = v.mready;
        m_rvalid = v.mrvalid;
        m_rdata  = v.mrdata;
    endtask

    task automatic compare(input int i, input vec_t v);
        check("i_gnt",    i, 32'(i_gnt),    32'(v.ig));
        check("d_gnt",    i, 32'(d_gnt),    32'(v.dg));
        check("i_rvalid", i, 32'(i_rvalid), 32'(v.irv));
        check("i_rdata",  i, i_rdata,       v.ird);
        check("d_rvalid", i, 32'(d_rvalid), 32'(v.drv));
        check("d_rdata",  i, d_rdata,       v.drd);
        check("m_req",    i, 32'(m_req),    32'(v.mreq));
        check("m_we",     i, 32'(m_we),     32'(v.mwe));
        check("m_addr",   i, m_addr,        v.maddr);
        check("m_wdata",  i, m_wdata,       v.mwdata);
        check("m_wstrb",  i, 32'(m_wstrb),  32'(v.mwstrb));
        check("busy",     i, 32'(busy),     32'(v.bsy));
        check("err",      i, 32'(err),      32'(v.er));
    endtask

    initial begin
        int exp_i[10];

        n_checks = 0;
        n_fail   = 0;

        //            ireq iaddr     dreq we daddr    dwdata       strb rdy rv rdata
        //            ig dg irv ird          drv drd         mreq we maddr  mwdata   strb bsy err
        // Fetch read: grant, accept next cycle, response two cycles after grant.
        vecs.push_back(mk(1, 'h100, 0, 0, 0, 0, 0, 1, 0, 0,
                          1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0,
                          0, 0, 0, 0, 0, 0, 1, 0, 'h100, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 'hDEADBEEF,
                          0, 0, 1, 'hDEADBEEF, 0, 0, 0, 0, 'h100, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                          0, 0, 0, 0, 0, 0, 0, 0, 'h100, 0, 0, 0, 0));
        // Data write, memory stalls 3 cycles; payload stays put, no rvalid.
        vecs.push_back(mk(0, 0, 1, 1, 'h2004, 'h12345678, 3, 0, 0, 0,
                          0, 1, 0, 0, 0, 0, 0, 0, 'h100, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                          0, 0, 0, 0, 0, 0, 1, 1, 'h2004, 'h12345678, 3, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                          0, 0, 0, 0, 0, 0, 1, 1, 'h2004, 'h12345678, 3, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                          0, 0, 0, 0, 0, 0, 1, 1, 'h2004, 'h12345678, 3, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0,
                          0, 0, 0, 0, 0, 0, 1, 1, 'h2004, 'h12345678, 3, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                          0, 0, 0, 0, 0, 0, 0, 1, 'h2004, 'h12345678, 3, 0, 0));
        // Stray response while idle: ignored, err rises next cycle and sticks.
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 'hCAFEF00D,
                          0, 0, 0, 0, 0, 0, 0, 1, 'h2004, 'h12345678, 3, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                          0, 0, 0, 0, 0, 0, 0, 1, 'h2004, 'h12345678, 3, 0, 1));
        // Following data read is serviced normally.
        vecs.push_back(mk(0, 0, 1, 0, 'h3000, 0, 0, 1, 0, 0,
                          0, 1, 0, 0, 0, 0, 0, 1, 'h2004, 'h12345678, 3, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0,
                          0, 0, 0, 0, 0, 0, 1, 0, 'h3000, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 'h55AA55AA,
                          0, 0, 0, 0, 1, 'h55AA55AA, 0, 0, 'h3000, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                          0, 0, 0, 0, 0, 0, 0, 0, 'h3000, 0, 0, 0, 1));
        // Back-to-back data reads: grant every 3 cycles, one idle cycle between.
        vecs.push_back(mk(0, 0, 1, 0, 'h40, 0, 0, 1, 0, 0,
                          0, 1, 0, 0, 0, 0, 0, 0, 'h3000, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 'h44, 0, 0, 1, 0, 0,
                          0, 0, 0, 0, 0, 0, 1, 0, 'h40, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 1, 0, 'h44, 0, 0, 1, 1, 'h11111111,
                          0, 0, 0, 0, 1, 'h11111111, 0, 0, 'h40, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 1, 0, 'h44, 0, 0, 1, 0, 0,
                          0, 1, 0, 0, 0, 0, 0, 0, 'h40, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0,
                          0, 0, 0, 0, 0, 0, 1, 0, 'h44, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 'h22222222,
                          0, 0, 0, 0, 1, 'h22222222, 0, 0, 'h44, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                          0, 0, 0, 0, 0, 0, 0, 0, 'h44, 0, 0, 0, 1));

        // Reset state, with both requests high: grants must stay low in reset.
        drive_idle();
        rst   = 1'b1;
        i_req = 1'b1;
        d_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_i_gnt",   0, 32'(i_gnt),   32'd0);
        check("rst_d_gnt",   0, 32'(d_gnt),   32'd0);
        check("rst_m_req",   0, 32'(m_req),   32'd0);
        check("rst_m_addr",  0, m_addr,       32'd0);
        check("rst_m_wdata", 0, m_wdata,      32'd0);
        check("rst_m_we",    0, 32'(m_we),    32'd0);
        check("rst_m_wstrb", 0, 32'(m_wstrb), 32'd0);
        check("rst_busy",    0, 32'(busy),    32'd0);
        check("rst_err",     0, 32'(err),     32'd0);

        @(negedge clk);
        rst = 1'b0;
        foreach (vecs[i]) begin
            if (i > 0) @(negedge clk);
            apply(vecs[i]);
            #1;
            compare(i, vecs[i]);
        end

        // Starvation: both sides request every cycle; each transaction is a read
        // accepted immediately with the response one cycle later.
        exp_i = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            drive_idle();
            i_req  = 1'b1;
            i_addr = 32'h1000 + 32'(k * 4);
            d_req  = 1'b1;
            d_addr = 32'h2000 + 32'(k * 4);
            #1;
            check("starve_i_gnt", k, 32'(i_gnt), 32'(exp_i[k]));
            check("starve_d_gnt", k, 32'(d_gnt), 32'(exp_i[k] == 0));
            @(negedge clk);
            m_ready = 1'b1;
            #1;
            check("starve_m_addr", k, m_addr,
                  (exp_i[k] != 0) ? 32'h1000 + 32'(k * 4) : 32'h2000 + 32'(k * 4));
            @(negedge clk);
            m_ready  = 1'b0;
            m_rvalid = 1'b1;
            m_rdata  = 32'(k);
            #1;
            check("starve_i_rvalid", k, 32'(i_rvalid), 32'(exp_i[k]));
            check("starve_d_rvalid", k, 32'(d_rvalid), 32'(exp_i[k] == 0));
        end

        // Reset while a data read waits; the response lands during reset.
        @(negedge clk);
        drive_idle();
        d_req   = 1'b1;
        d_addr  = 32'h500;
        m_ready = 1'b1;
        #1;
        check("rw_d_gnt", 0, 32'(d_gnt), 32'd1);
        @(negedge clk);
        d_req = 1'b0;
        #1;
        check("rw_m_req", 0, 32'(m_req), 32'd1);
        @(negedge clk);
        rst      = 1'b1;
        m_ready  = 1'b0;
        m_rvalid = 1'b1;
        m_rdata  = 32'hBAD;
        #1;
        check("rw_d_rvalid", 0, 32'(d_rvalid), 32'd0);
        check("rw_busy",     0, 32'(busy),     32'd0);
        check("rw_err",      0, 32'(err),      32'd0);
        check("rw_m_addr",   0, m_addr,        32'd0);
        @(negedge clk);
        rst      = 1'b0;
        m_rvalid = 1'b0;
        #1;
        check("rw_post_d_rvalid", 1, 32'(d_rvalid), 32'd0);
        check("rw_post_busy",     1, 32'(busy),     32'd0);
        check("rw_post_err",      1, 32'(err),      32'd0);

        // A fetch read after reset goes through cleanly.
        @(negedge clk);
        i_req   = 1'b1;
        i_addr  = 32'h600;
        m_ready = 1'b1;
        #1;
        check("post_i_gnt", 0, 32'(i_gnt), 32'd1);
        @(negedge clk);
        i_req = 1'b0;
        #1;
        check("post_m_req",  0, 32'(m_req), 32'd1);
        check("post_m_addr", 0, m_addr,     32'h600);
        @(negedge clk);
        m_ready  = 1'b0;
        m_rvalid = 1'b1;
        m_rdata  = 32'h0A0B0C0D;
        #1;
        check("post_i_rvalid", 0, 32'(i_rvalid), 32'd1);
        check("post_i_rdata",  0, i_rdata,       32'h0A0B0C0D);
        check("post_d_rvalid", 0, 32'(d_rvalid), 32'd0);
        @(negedge clk);
        drive_idle();
        #1;
        check("post_busy", 0, 32'(busy), 32'd0);
        check("post_err",  0, 32'(err),  32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
